// File: rtl/accumulator_control_unit.sv
// Control FSM for the accumulator machine: fetches from a 32-word sync ROM, decodes
// the 3-bit opcode and drives the A-mux / register-A / add-sub controls.
module accumulator_control_unit #(
    parameter int n = 8,
    parameter int a = 5
) (
    input  logic         clk,
    input  logic         resetN,
    output logic [a-1:0] romAddr,
    input  logic [n-1:0] romData,
    input  logic         inValid,
    output logic         inReady,
    input  logic [n-1:0] regAOut,
    input  logic         Aeq0,
    input  logic         Apos,
    output logic [n-1:0] IROut,
    output logic [1:0]   Asel,
    output logic         loadA,
    output logic         clearA,
    output logic         sub,
    output logic [n-1:0] outData,
    output logic         outValid,
    output logic         halted,
    output logic [2:0]   dbg_state
);

    // IN handshake: inValid is level-held by the source; inReady pulses for the one
    // cycle in which the word is loaded into A, and only while waiting in INWAIT.

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_INWAIT = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_IN   = 3'b000;
    localparam logic [2:0] OP_OUT  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_JPOS = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ASEL_SUBOUT = 2'd0;
    localparam logic [1:0] ASEL_INPUT  = 2'd1;
    localparam logic [1:0] ASEL_IR     = 2'd2;

    state_t         state_q, state_d;
    logic [a-1:0]   pc_q, pc_d;
    logic [n-1:0]   ir_q, ir_d;
    logic [n-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic [2:0]     opcode;
    logic [a-1:0]   operand;

    // The opcode occupies the top three IR bits, which requires n == a + 3.
    assign opcode  = ir_q[n-1 -: 3];
    assign operand = ir_q[a-1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        Asel        = ASEL_SUBOUT;
        loadA       = 1'b0;
        clearA      = 1'b0;
        sub         = 1'b0;
        inReady     = 1'b0;

        case (state_q)
            S_INIT: begin
                clearA  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = romData;
                pc_d    = pc_q + a'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_IN:   state_d = S_INWAIT;
                    OP_OUT: begin
                        out_data_d  = regAOut;
                        out_valid_d = 1'b1;
                    end
                    OP_LDI: begin
                        Asel  = ASEL_IR;
                        loadA = 1'b1;
                    end
                    OP_ADD: begin
                        loadA = 1'b1;
                    end
                    OP_SUB: begin
                        sub   = 1'b1;
                        loadA = 1'b1;
                    end
                    // A is not written during a jump, so the status flags are stable here.
                    OP_JZ:   if (Aeq0) pc_d = operand;
                    OP_JPOS: if (Apos) pc_d = operand;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_INWAIT: begin
                if (inValid) begin
                    Asel    = ASEL_INPUT;
                    loadA   = 1'b1;
                    inReady = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_INIT;
            pc_q        <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign romAddr   = pc_q;
    assign IROut     = {{(n-a){1'b0}}, operand};
    assign outData   = out_data_q;
    assign outValid  = out_valid_q;
    assign halted    = (state_q == S_HALT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Bench for accumulator_control_unit: behavioural ROM + datapath around the DUT and an
// instruction-level reference that predicts every cycle's observable outputs.
module tb_accumulator_control_unit;

    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       resetN;
    logic [4:0] romAddr;
    logic [7:0] romData;
    logic       inValid;
    logic       inReady;
    logic [7:0] regAOut;
    logic       Aeq0;
    logic       Apos;
    logic [7:0] IROut;
    logic [1:0] Asel;
    logic       loadA;
    logic       clearA;
    logic       sub;
    logic [7:0] outData;
    logic       outValid;
    logic       halted;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    accumulator_control_unit #(.n(8), .a(5)) dut (
        .clk(clk), .resetN(resetN), .romAddr(romAddr), .romData(romData),
        .inValid(inValid), .inReady(inReady), .regAOut(regAOut), .Aeq0(Aeq0),
        .Apos(Apos), .IROut(IROut), .Asel(Asel), .loadA(loadA), .clearA(clearA),
        .sub(sub), .outData(outData), .outValid(outValid), .halted(halted),
        .dbg_state(dbg_state)
    );

    // Program ROM and accumulator datapath
    logic [7:0] rom [32];
    logic [7:0] a_reg;
    logic [7:0] in_word;
    logic       ovr_en, ovr_aeq, ovr_apos;

    always_ff @(posedge clk) romData <= rom[romAddr];

    always_ff @(posedge clk) begin
        if (clearA) a_reg <= 8'h00;
        else if (loadA) begin
            case (Asel)
                2'd0:    a_reg <= sub ? a_reg - IROut : a_reg + IROut;
                2'd1:    a_reg <= in_word;
                2'd2:    a_reg <= IROut;
                default: a_reg <= 8'h00;
            endcase
        end
    end

    assign regAOut = a_reg;
    assign Aeq0    = ovr_en ? ovr_aeq  : (a_reg == 8'h00);
    assign Apos    = ovr_en ? ovr_apos : !a_reg[7];

    // Stimulus schedule and predicted observables, indexed by cycle after reset release
    logic       iv [MAXC];
    logic [7:0] din [MAXC];
    bit         rnd_ovr;
    logic [4:0] e_addr [MAXC];
    bit         e_outv [MAXC];
    logic [7:0] e_outd [MAXC];
    bit         e_inrdy [MAXC];
    bit         e_halt [MAXC];
    bit         e_av [MAXC];
    logic [7:0] e_a [MAXC];

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cur_cyc = 0;
    int         n_outs;
    logic [7:0] last_out;

    localparam logic [28:0] RESET_PACK =
        {5'd0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

    function automatic logic [28:0] pack_outs();
        return {romAddr, IROut, Asel, loadA, clearA, sub, outData, outValid, halted, inReady};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cur_cyc, act, exp);
        end
    endtask

    // Instruction-level interpretation: 3 cycles per instruction after the INIT cycle,
    // IN waits until the first cycle with inValid after EXEC, HALT freezes forever.
    function automatic void build_model(input int ncyc);
        int         c, e, nx, w;
        logic [4:0] pc, npc, opd;
        logic [7:0] acc, ins;
        logic [2:0] op;
        for (int i = 0; i < MAXC; i++) begin
            e_addr[i] = 5'd0; e_outv[i] = 0; e_outd[i] = 8'h00; e_inrdy[i] = 0;
            e_halt[i] = 0; e_av[i] = 0; e_a[i] = 8'h00;
        end
        pc = 5'd0; acc = 8'h00; c = 1;
        while (c < ncyc) begin
            ins = rom[pc]; op = ins[7:5]; opd = ins[4:0];
            e_av[c] = 1; e_a[c] = acc;
            e_addr[c] = pc;
            if (c + 1 < ncyc) e_addr[c+1] = pc;
            npc = pc + 5'd1; e = c + 2; nx = c + 3;
            case (op)
                3'd0: begin
                    w = e + 1;
                    while (w < ncyc && !iv[w]) w++;
                    if (w < ncyc) begin e_inrdy[w] = 1; acc = din[w]; end
                    nx = w + 1;
                end
                3'd1: if (e + 1 < ncyc) begin e_outv[e+1] = 1; e_outd[e+1] = acc; end
                3'd2: acc = {3'b000, opd};
                3'd3: acc = acc + {3'b000, opd};
                3'd4: acc = acc - {3'b000, opd};
                3'd5: if (acc == 8'h00) npc = opd;
                3'd6: if (!acc[7]) npc = opd;
                default: begin
                    for (int k = e + 1; k < ncyc; k++) e_halt[k] = 1;
                    nx = ncyc;
                end
            endcase
            for (int k = e; k < nx && k < ncyc; k++) e_addr[k] = pc + 5'd1;
            pc = npc; c = nx;
        end
    endfunction

    task automatic check_cycle(input int c);
        chk("rom_addr", romAddr, e_addr[c]);
        chk("clear_a", clearA, c == 0);
        chk("out_valid", outValid, e_outv[c]);
        if (e_outv[c]) chk("out_data", outData, e_outd[c]);
        chk("in_ready", inReady, e_inrdy[c]);
        chk("halted", halted, e_halt[c]);
        if (e_av[c]) chk("acc_at_fetch", a_reg, e_a[c]);
        chk("load_clear_excl", loadA & clearA, 0);
        if (inReady) chk("in_ctrl", {loadA, Asel}, 3'b101);
        if (e_halt[c]) chk("halt_quiet", {loadA, clearA, sub, Asel, inReady, outValid}, 0);
        if (outValid) begin n_outs++; last_out = outData; end
    endtask

    task automatic run_prog(input int ncyc);
        build_model(ncyc);
        resetN = 1'b0; inValid = 1'b0; in_word = 8'h00; ovr_en = 1'b0;
        ovr_aeq = 1'b0; ovr_apos = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        cur_cyc = -1;
        chk("reset_outs", pack_outs(), RESET_PACK);
        resetN = 1'b1; n_outs = 0; last_out = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            cur_cyc = c;
            inValid = iv[c]; in_word = din[c];
            if (rnd_ovr) begin
                ovr_en = 1'b1;
                ovr_aeq = 1'($urandom_range(0, 1));
                ovr_apos = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check_cycle(c);
        end
    endtask

    typedef struct {
        logic [5:0][7:0] prog;
        int              plen;
        logic [7:0]      fill;
        int              ncyc;
        int              in_cyc;
        logic [7:0]      in_val;
        bit              rnd;
        logic [7:0]      exp_a;
        logic [4:0]      exp_addr;
        bit              exp_halt;
        int              exp_outs;
        logic [7:0]      exp_last;
    } vec_t;

    vec_t vt [5];

    initial begin
        // countdown loop, IN wait, tight JPOS loop, ADD-1 everywhere, immediate HALT
        vt[0] = '{48'h0000E020C1A4_8143 >> 0, 6, 8'h00, 60, -1, 8'h00, 0, 8'h00, 5'd6, 1, 1, 8'h00};
        vt[1] = '{48'h000000E02000, 3, 8'h00, 40, 14, 8'h5A, 0, 8'h5A, 5'd3, 1, 1, 8'h5A};
        vt[2] = '{48'h00000000C05F, 2, 8'h00, 120, -1, 8'h00, 0, 8'h1F, 5'd1, 0, 0, 8'h00};
        vt[3] = '{48'h000000000000, 0, 8'h61, 800, -1, 8'h00, 0, 8'h0A, 5'd10, 0, 0, 8'h00};
        vt[4] = '{48'h0000000000E0, 1, 8'h00, 60, -1, 8'h00, 1, 8'h00, 5'd1, 1, 0, 8'h00};
        vt[0].prog = 48'hE020C1A48143;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = vt[t].fill;
                if (i < vt[t].plen) rom[i] = vt[t].prog[i];
            end
            for (int i = 0; i < MAXC; i++) begin
                iv[i]  = (vt[t].rnd != 0) ? 1'($urandom_range(0, 1)) : (i == vt[t].in_cyc);
                din[i] = (i == vt[t].in_cyc) ? vt[t].in_val : 8'($urandom_range(0, 255));
            end
            rnd_ovr = vt[t].rnd;
            run_prog(vt[t].ncyc);
            chk("final_a", a_reg, vt[t].exp_a);
            chk("final_addr", romAddr, vt[t].exp_addr);
            chk("final_halt", halted, vt[t].exp_halt);
            chk("n_outs", n_outs, vt[t].exp_outs);
            chk("last_out", last_out, vt[t].exp_last);
        end

        // Asynchronous reset in the EXEC cycle of a SUB, with a non-zero output latch
        rnd_ovr = 0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h45; rom[1] = 8'h20; rom[2] = 8'h81; rom[3] = 8'hE0;
        for (int i = 0; i < MAXC; i++) begin iv[i] = 1'b0; din[i] = 8'h00; end
        run_prog(10);
        chk("pre_rst_sub", {sub, loadA}, 2'b11);
        chk("pre_rst_out", outData, 8'h05);
        #2 resetN = 1'b0;
        #1 chk("async_reset", pack_outs(), RESET_PACK);
        run_prog(20);
        chk("post_rst_a", a_reg, 8'h04);

        // Random programs with random IN timing
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                if (b[7:5] == 3'd7 && $urandom_range(0, 3) != 0) b[7:5] = 3'd3;
                rom[i] = b;
            end
            for (int i = 0; i < MAXC; i++) begin
                iv[i]  = ($urandom_range(0, 2) == 0);
                din[i] = 8'($urandom_range(0, 255));
            end
            rnd_ovr = 0;
            run_prog(300);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
